// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage datapath (PC/latch enables, flushes, halt, stall count)
//   CLK, RST                 clock and synchronous active-high reset
//   ihit, dhit               I-cache / D-cache completion this cycle
//   memreq_MEM, memread_EX   MEM-stage memory access, EX-stage load
//   destEX, rsID, rtID       register indices used for load-use detection
//   useRt_ID                 ID-stage instruction reads rt
//   brtaken_MEM, halt_MEM    taken branch / HALT resolved in MEM
//   pc_en, en_*, flush_*     PC enable, latch enables and bubble-loads
//   halt, stall_cnt          sticky halt, saturating count of PC-stalled cycles
module hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             memreq_MEM,
  input  logic             memread_EX,
  input  logic [REG_W-1:0] destEX,
  input  logic [REG_W-1:0] rsID,
  input  logic [REG_W-1:0] rtID,
  input  logic             useRt_ID,
  input  logic             brtaken_MEM,
  input  logic             halt_MEM,
  output logic             pc_en,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int LW = LU_STALL > 1 ? $clog2(LU_STALL) : 1;
  typedef enum logic [1:0] {RUN, LUSTALL, DWAIT, HALTED} state_t;
  state_t state, state_d, eff;
  logic [LW-1:0] lu_cnt, lu_d;
  logic dwait, load_use;
  assign dwait    = memreq_MEM & ~dhit;
  assign load_use = memread_EX & (destEX != '0) & ((rsID == destEX) | (useRt_ID & (rtID == destEX)));
  // leaving DWAIT resumes whatever was frozen: a pending load-use bubble run, or plain RUN
  assign eff = (state == DWAIT) ? (lu_cnt != '0 ? LUSTALL : RUN) : state;
  always_comb begin
    state_d     = state;
    lu_d        = lu_cnt;
    pc_en       = 1'b0;
    en_ifid     = 1'b0;
    en_idex     = 1'b0;
    en_exmem    = 1'b0;
    en_memwb    = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    if (RST) begin
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
    end else if (state == HALTED) begin
      state_d = HALTED;
    end else if (dwait) begin
      state_d = DWAIT;
    end else if (halt_MEM) begin
      en_memwb = 1'b1;
      state_d  = HALTED;
    end else if (brtaken_MEM) begin
      {pc_en, en_ifid, en_idex, en_exmem, en_memwb} = '1;
      {flush_ifid, flush_idex, flush_exmem}         = '1;
      lu_d    = '0;
      state_d = RUN;
    end else if (eff == LUSTALL || load_use) begin
      // hold IF/ID and PC, push a bubble into ID/EX, let the load move on
      en_idex    = 1'b1;
      flush_idex = 1'b1;
      en_exmem   = 1'b1;
      en_memwb   = 1'b1;
      lu_d       = eff == LUSTALL ? lu_cnt - 1'b1 : LW'(LU_STALL - 1);
      state_d    = eff == LUSTALL ? (lu_cnt == LW'(1) ? RUN : LUSTALL) : (LU_STALL > 1 ? LUSTALL : RUN);
    end else begin
      {en_ifid, en_idex, en_exmem, en_memwb} = '1;
      pc_en      = ihit;
      flush_ifid = ~ihit;
      state_d    = RUN;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      lu_cnt    <= '0;
      halt      <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state  <= state_d;
      lu_cnt <= lu_d;
      halt   <= halt | (state_d == HALTED);
      if (~pc_en && state != HALTED && ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule
